// File: rtl/lockin_lpf_pkg.sv
// Shared constants and helpers for the lock-in I/Q low-pass filter.
// Accumulator sizing, settle-time scaling and output saturation limits live here.
package lockin_pkg;

  localparam int W_IN_DEF    = 32;
  localparam int W_OUT_DEF   = 16;
  localparam int G_DEF       = 16;
  localparam int DEC_W_DEF   = 8;
  localparam int SETTLE_MULT = 8;
  localparam int SETTLE_W    = 19;

  // One extra bit above the shifted input keeps the difference term from wrapping.
  function automatic int acc_width(input int w_in, input int g);
    return w_in + g + 1;
  endfunction

  function automatic logic signed [31:0] sat_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] sat_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/lockin_lpf_if.sv
// Sample/result bus between the mixer stage and the I/Q low-pass filter.
// The master supplies products; the slave (filter) returns decimated estimates.
interface lockin_lpf_if #(
  parameter int W_IN  = 32,
  parameter int W_OUT = 16
);

  logic                    in_valid;
  logic signed [W_IN-1:0]  i_in;
  logic signed [W_IN-1:0]  q_in;
  logic                    out_valid;
  logic signed [W_OUT-1:0] i_out;
  logic signed [W_OUT-1:0] q_out;

  modport master (
    output in_valid, i_in, q_in,
    input  out_valid, i_out, q_out
  );

  modport slave (
    input  in_valid, i_in, q_in,
    output out_valid, i_out, q_out
  );

endinterface

// File: rtl/lockin_lpf_channel.sv
// One channel of the first-order IIR: acc += ((x << G) - acc) >>> k,
// then round-half-up to W_OUT bits with saturation and a sticky overflow flag.
module lpf_channel
  import lockin_pkg::*;
#(
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int G     = G_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    upd,
  input  logic                    load,
  input  logic [3:0]              k,
  input  logic signed [W_IN-1:0]  x,
  output logic signed [W_OUT-1:0] y,
  output logic                    ovf
);

  localparam int AW = acc_width(W_IN, G);
  localparam int FB = W_IN + G - W_OUT;
  localparam logic signed [W_OUT+1:0] HI_S  = (W_OUT+2)'(sat_max(W_OUT));
  localparam logic signed [W_OUT+1:0] LO_S  = (W_OUT+2)'(sat_min(W_OUT));
  localparam logic signed [W_OUT-1:0] Y_MAX = W_OUT'(sat_max(W_OUT));
  localparam logic signed [W_OUT-1:0] Y_MIN = W_OUT'(sat_min(W_OUT));

  logic signed [AW-1:0]    acc_r;
  logic signed [AW-1:0]    x_ext_s;
  logic signed [AW-1:0]    diff_s;
  logic signed [AW-1:0]    step_s;
  logic signed [AW-1:0]    acc_next_s;
  logic signed [W_OUT:0]   top_s;
  logic                    rnd_s;
  logic signed [W_OUT+1:0] rsum_s;
  logic signed [W_OUT-1:0] y_next_s;
  logic                    sat_s;
  logic signed [W_OUT-1:0] y_r;
  logic                    ovf_r;

  // Accumulator update; the difference stays within AW bits because acc tracks the input range.
  always_comb begin
    x_ext_s    = {{(AW-W_IN){x[W_IN-1]}}, x} <<< G;
    diff_s     = x_ext_s - acc_r;
    step_s     = diff_s >>> k;
    acc_next_s = acc_r + step_s;
  end

  // Round half up on the bit below the output LSB, then clamp to the W_OUT range.
  always_comb begin
    top_s  = acc_r[AW-1:FB];
    rnd_s  = acc_r[FB-1];
    rsum_s = {top_s[W_OUT], top_s} + {{(W_OUT+1){1'b0}}, rnd_s};
    if (rsum_s > HI_S) begin
      y_next_s = Y_MAX;
      sat_s    = 1'b1;
    end else if (rsum_s < LO_S) begin
      y_next_s = Y_MIN;
      sat_s    = 1'b1;
    end else begin
      y_next_s = rsum_s[W_OUT-1:0];
      sat_s    = 1'b0;
    end
  end

  // Filter state, output register and sticky overflow; clear leaves the output holding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= '0;
      y_r   <= '0;
      ovf_r <= 1'b0;
    end else if (clear) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      if (upd) begin
        acc_r <= acc_next_s;
      end
      if (load) begin
        y_r <= y_next_s;
        if (sat_s) begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  assign y   = y_r;
  assign ovf = ovf_r;

endmodule

// File: rtl/lockin_lpf.sv
// Dual-channel (I/Q) first-order low-pass filter with programmable time constant
// and decimation; owns sample counting, settle tracking and the two-stage valid pipeline.
module lockin_lpf
  import lockin_pkg::*;
#(
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int G     = G_DEF,
  parameter int DEC_W = DEC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  lockin_lpf_if.slave      bus,
  input  logic [3:0]       k,
  input  logic [DEC_W-1:0] dec_ratio,
  input  logic             clear,
  output logic             settled,
  output logic             ovf
);

  localparam logic [SETTLE_W-1:0] SETTLE_BASE = SETTLE_W'(SETTLE_MULT);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};
  localparam logic [SETTLE_W-1:0] SETTLE_MAX  = {SETTLE_W{1'b1}};

  logic [3:0]          k_r;
  logic [DEC_W-1:0]    dec_cnt_r;
  logic [SETTLE_W-1:0] settle_r;
  logic                settled_r;
  logic                v1_r;
  logic                out_valid_r;
  logic                ovf_r;

  logic [DEC_W-1:0]    ratio_s;
  logic [DEC_W:0]      cnt_inc_s;
  logic                emit_s;
  logic [SETTLE_W-1:0] settle_next_s;
  logic [SETTLE_W-1:0] thr_s;
  logic                upd_s;
  logic signed [W_OUT-1:0] i_y_s;
  logic signed [W_OUT-1:0] q_y_s;
  logic                i_ovf_s;
  logic                q_ovf_s;

  // Decimation compare: a ratio of zero behaves as one, so every sample emits.
  always_comb begin
    if (dec_ratio == {DEC_W{1'b0}}) begin
      ratio_s = {{(DEC_W-1){1'b0}}, 1'b1};
    end else begin
      ratio_s = dec_ratio;
    end
    cnt_inc_s = {1'b0, dec_cnt_r} + {{DEC_W{1'b0}}, 1'b1};
    emit_s    = (cnt_inc_s >= {1'b0, ratio_s});
  end

  // Settle count restarts at this sample when k changes, otherwise saturating increment.
  always_comb begin
    thr_s = SETTLE_BASE << k;
    if (k != k_r) begin
      settle_next_s = SETTLE_ONE;
    end else if (settle_r == SETTLE_MAX) begin
      settle_next_s = settle_r;
    end else begin
      settle_next_s = settle_r + SETTLE_ONE;
    end
  end

  assign upd_s = bus.in_valid & ~clear;

  // Sample bookkeeping and the valid pipeline (T: sample, T+1: acc, T+2: output).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_r         <= 4'd0;
      dec_cnt_r   <= '0;
      settle_r    <= '0;
      settled_r   <= 1'b0;
      v1_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (clear) begin
      dec_cnt_r   <= '0;
      settle_r    <= '0;
      settled_r   <= 1'b0;
      v1_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= v1_r;
      v1_r        <= bus.in_valid & emit_s;
      if (bus.in_valid) begin
        k_r       <= k;
        dec_cnt_r <= emit_s ? {DEC_W{1'b0}} : cnt_inc_s[DEC_W-1:0];
        settle_r  <= settle_next_s;
        settled_r <= (settle_next_s >= thr_s);
      end
    end
  end

  // Combined sticky overflow, registered from the per-channel flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (clear) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= i_ovf_s | q_ovf_s;
    end
  end

  lpf_channel #(.W_IN(W_IN), .W_OUT(W_OUT), .G(G)) u_i (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .upd   (upd_s),
    .load  (v1_r),
    .k     (k),
    .x     (bus.i_in),
    .y     (i_y_s),
    .ovf   (i_ovf_s)
  );

  lpf_channel #(.W_IN(W_IN), .W_OUT(W_OUT), .G(G)) u_q (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .upd   (upd_s),
    .load  (v1_r),
    .k     (k),
    .x     (bus.q_in),
    .y     (q_y_s),
    .ovf   (q_ovf_s)
  );

  assign bus.i_out     = i_y_s;
  assign bus.q_out     = q_y_s;
  assign bus.out_valid = out_valid_r;
  assign settled       = settled_r;
  assign ovf           = ovf_r;

endmodule

// File: tb/tb_lockin_lpf.sv
// Directed bench for lockin_lpf: table of k=0 pass-through vectors plus
// hand-written step, decimation, clear, k-change and async-reset sequences.
module tb_lockin_lpf;

  logic       clk;
  logic       rst;
  logic [3:0] k;
  logic [7:0] dec_ratio;
  logic       clear;
  logic       settled;
  logic       ovf;

  int nchk;
  int nerr;

  lockin_lpf_if #(.W_IN(32), .W_OUT(16)) bus ();

  lockin_lpf #(.W_IN(32), .W_OUT(16), .G(16), .DEC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .k         (k),
    .dec_ratio (dec_ratio),
    .clear     (clear),
    .settled   (settled),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i_in;
    logic [31:0] q_in;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    nchk++;
    if (act < lo || act > hi) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic sample(input logic [31:0] xi, input logic [31:0] xq);
    bus.in_valid = 1'b1;
    bus.i_in     = xi;
    bus.q_in     = xq;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input int n, input logic [31:0] xi, input logic [31:0] xq);
    bus.in_valid = 1'b1;
    bus.i_in     = xi;
    bus.q_in     = xq;
    for (int j = 0; j < n; j++) tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int npulse;
    nchk = 0;
    nerr = 0;

    vecs[0] = '{32'h12345678, 32'h12348000, 16'h1234, 16'h1235, 1'b0};
    vecs[1] = '{32'h00000000, 32'hFFFFFFFF, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{32'h80000000, 32'h7FFF7FFF, 16'h8000, 16'h7FFF, 1'b0};
    vecs[3] = '{32'hFFFE8000, 32'h00018000, 16'hFFFF, 16'h0002, 1'b0};
    vecs[4] = '{32'hABCD7FFF, 32'h5A5A0001, 16'hABCD, 16'h5A5A, 1'b0};
    vecs[5] = '{32'h7FFF8000, 32'h00000000, 16'h7FFF, 16'h0000, 1'b1};

    rst          = 1'b0;
    clear        = 1'b0;
    k            = 4'd0;
    dec_ratio    = 8'd1;
    bus.in_valid = 1'b0;
    bus.i_in     = 32'h0;
    bus.q_in     = 32'h0;
    #2;
    chk("reset_i_out", {16'h0, bus.i_out}, 32'h0);
    chk("reset_q_out", {16'h0, bus.q_out}, 32'h0);
    chk("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("reset_settled", {31'h0, settled}, 32'h0);
    chk("reset_ovf", {31'h0, ovf}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Pass-through table at k=0, dec=1
    for (int v = 0; v < 6; v++) begin
      sample(vecs[v].i_in, vecs[v].q_in);
      chk($sformatf("v%0d_latency", v), {31'h0, bus.out_valid}, 32'h0);
      tick();
      chk($sformatf("v%0d_out_valid", v), {31'h0, bus.out_valid}, 32'h1);
      chk($sformatf("v%0d_i_out", v), {16'h0, bus.i_out}, {16'h0, vecs[v].exp_i});
      chk($sformatf("v%0d_q_out", v), {16'h0, bus.q_out}, {16'h0, vecs[v].exp_q});
      tick();
      chk($sformatf("v%0d_one_shot", v), {31'h0, bus.out_valid}, 32'h0);
      chk($sformatf("v%0d_ovf", v), {31'h0, ovf}, {31'h0, vecs[v].exp_ovf});
    end

    // ovf is sticky across a clean sample, cleared by clear; outputs hold
    sample(32'h00010000, 32'h0);
    tick();
    tick();
    chk("ovf_sticky", {31'h0, ovf}, 32'h1);
    chk("post_sat_i_out", {16'h0, bus.i_out}, 32'h1);
    do_clear();
    chk("ovf_cleared", {31'h0, ovf}, 32'h0);
    chk("clear_holds_i_out", {16'h0, bus.i_out}, 32'h1);

    // Step response at k=4
    k = 4'd4;
    run(16, 32'h40000000, 32'hC0000000);
    tick();
    chk_rng("step_i_out", int'(bus.i_out), 10548, 10552);
    chk_rng("step_q_out", int'(bus.q_out), -10552, -10548);
    run(111, 32'h40000000, 32'hC0000000);
    chk("settled_127", {31'h0, settled}, 32'h0);
    run(1, 32'h40000000, 32'hC0000000);
    chk("settled_128", {31'h0, settled}, 32'h1);

    // Decimation by 5, samples spaced 3 cycles
    do_clear();
    k = 4'd0;
    dec_ratio = 8'd5;
    npulse = 0;
    for (int s = 1; s <= 20; s++) begin
      sample(32'(s) << 16, 32'h0);
      tick();
      chk($sformatf("dec5_s%0d", s), {31'h0, bus.out_valid}, {31'h0, (s % 5) == 0});
      if (bus.out_valid) begin
        npulse++;
        chk($sformatf("dec5_val_s%0d", s), {16'h0, bus.i_out}, 32'(s));
      end
      tick();
    end
    chk("dec5_pulses", 32'(npulse), 32'd4);

    // Lowering the ratio below the current count emits on the next sample
    do_clear();
    for (int s = 0; s < 3; s++) sample(32'h00070000, 32'h0);
    dec_ratio = 8'd2;
    sample(32'h00090000, 32'h0);
    tick();
    chk("dec_change_emit", {31'h0, bus.out_valid}, 32'h1);
    chk("dec_change_val", {16'h0, bus.i_out}, 32'h9);

    // dec_ratio=0 behaves as 1, back-to-back samples
    dec_ratio = 8'd0;
    bus.in_valid = 1'b1;
    bus.i_in = 32'h00030000;
    tick();
    tick();
    chk("dec0_p1", {31'h0, bus.out_valid}, 32'h1);
    tick();
    chk("dec0_p2", {31'h0, bus.out_valid}, 32'h1);
    bus.in_valid = 1'b0;
    tick();
    chk("dec0_p3", {31'h0, bus.out_valid}, 32'h1);
    tick();
    chk("dec0_end", {31'h0, bus.out_valid}, 32'h0);

    // Steady state then clear colliding with in_valid
    do_clear();
    k = 4'd4;
    dec_ratio = 8'd1;
    run(700, 32'h40000000, 32'h40000000);
    tick();
    chk("steady_i_out", {16'h0, bus.i_out}, 32'h4000);
    chk("steady_settled", {31'h0, settled}, 32'h1);
    bus.in_valid = 1'b1;
    clear = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    clear = 1'b0;
    tick();
    chk("collide_no_valid_a", {31'h0, bus.out_valid}, 32'h0);
    tick();
    chk("collide_no_valid_b", {31'h0, bus.out_valid}, 32'h0);
    chk("collide_settled", {31'h0, settled}, 32'h0);
    chk("collide_hold_i", {16'h0, bus.i_out}, 32'h4000);
    sample(32'h0, 32'h0);
    tick();
    chk("after_clear_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("after_clear_i_out", {16'h0, bus.i_out}, 32'h0);
    chk("after_clear_settled", {31'h0, settled}, 32'h0);

    // clear during the accumulate stage suppresses the pending output
    sample(32'h00050000, 32'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_t1_a", {31'h0, bus.out_valid}, 32'h0);
    tick();
    chk("clear_t1_b", {31'h0, bus.out_valid}, 32'h0);
    chk("clear_t1_hold", {16'h0, bus.i_out}, 32'h0);

    // k change 4 -> 6 restarts settling
    run(128, 32'h0, 32'h0);
    chk("k4_settled", {31'h0, settled}, 32'h1);
    k = 4'd6;
    run(1, 32'h0, 32'h0);
    chk("k6_drop", {31'h0, settled}, 32'h0);
    run(510, 32'h0, 32'h0);
    chk("k6_511", {31'h0, settled}, 32'h0);
    run(1, 32'h0, 32'h0);
    chk("k6_512", {31'h0, settled}, 32'h1);

    // Async reset the cycle after an emitting sample
    do_clear();
    k = 4'd0;
    run(10, 32'h7FFF8000, 32'h7FFF8000);
    tick();
    tick();
    chk("pre_rst_ovf", {31'h0, ovf}, 32'h1);
    chk("pre_rst_settled", {31'h0, settled}, 32'h1);
    sample(32'h12345678, 32'h12345678);
    rst = 1'b0;
    #1;
    chk("arst_i_out", {16'h0, bus.i_out}, 32'h0);
    chk("arst_q_out", {16'h0, bus.q_out}, 32'h0);
    chk("arst_ovf", {31'h0, ovf}, 32'h0);
    chk("arst_settled", {31'h0, settled}, 32'h0);
    chk("arst_valid", {31'h0, bus.out_valid}, 32'h0);
    tick();
    chk("arst_valid_b", {31'h0, bus.out_valid}, 32'h0);
    rst = 1'b1;
    tick();
    chk("arst_valid_c", {31'h0, bus.out_valid}, 32'h0);
    tick();
    chk("arst_valid_d", {31'h0, bus.out_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/lockin_lpf.md
Name: lockin_lpf

Overview:
Dual-channel (I/Q) first-order IIR low-pass filter with decimation. It sits directly downstream of the mixer multipliers (mult16x16 products of the input signal with DDS sin/cos). It removes the 2f mixing term and produces decimated, rounded, saturated I/Q estimates for readout/UART. Time constant and decimation ratio are runtime-programmable.

Parameters:
W_IN, 32, signed width of mixer products i_in/q_in
W_OUT, 16, signed width of filtered outputs
G, 16, guard (fraction) bits below input LSB in accumulator
DEC_W, 8, width of decimation-ratio input

Ports:
clk  in  1  system clock (PLL clock domain)
rst  in  1  asynchronous active-low reset
in_valid  in  1  one-cycle strobe: i_in/q_in hold a new product
i_in  in  W_IN  signed in-phase product
q_in  in  W_IN  signed quadrature product
k  in  4  filter shift, alpha = 2^-k (0..15); sampled on each in_valid
dec_ratio  in  DEC_W  output every dec_ratio samples; 0 treated as 1
clear  in  1  synchronous clear of filter state
i_out  out  W_OUT  filtered I, registered
q_out  out  W_OUT  filtered Q, registered
out_valid  out  1  one-cycle strobe: new i_out/q_out
settled  out  1  filter has run >= 8*2^k samples at current k
ovf  out  1  sticky: output saturation occurred

Behaviour:
- Reset (rst=0, async): accumulators, decimation counter, settle counter, i_out, q_out, out_valid, settled, ovf all 0; stored k = 0.
- Accumulator per channel: signed, W_IN+G+1 bits. On in_valid: acc <= acc + (((x <<< G) - acc) >>> k), arithmetic shift, truncating. Bounded by input range; no wrap possible.
- k=0: acc = x<<<G exactly (pass-through).
- Output conversion: take acc bits [W_IN+G-1 -: W_OUT], add round bit acc[W_IN+G-W_OUT-1] (round half up). If the result exceeds +max, clamp to 0x7FFF (W_OUT=16) and set ovf. Negative overflow is impossible, but is still clamped to 0x8000 for safety.
- Pipeline: cycle T in_valid; T+1 acc updated; if decimation point, T+2 i_out/q_out loaded and out_valid=1 for exactly one cycle. Latency 2 cycles, fully pipelined; back-to-back in_valid is legal.
- Decimation counter: increments on each in_valid. When count+1 >= max(dec_ratio,1), the sample is an emit point and the counter resets to 0. A dec_ratio change takes effect at the next comparison; if the counter is already >= the new ratio, the next sample emits.
- Outputs hold their last value between out_valid strobes.
- k handling: latched on in_valid. A change of k versus the stored value zeroes the settle counter and deasserts settled; the accumulator is not cleared.
- Settle counter: 19-bit, saturating; increments per in_valid. settled=1 when count >= 8<<k.
- clear: synchronous. It zeroes accumulators, the decimation counter, the settle counter, settled, ovf and the pipeline valid. i_out/q_out hold. clear with in_valid in the same cycle: clear wins, the sample is dropped, and no out_valid results. clear during the T+1 stage suppresses the pending out_valid.
- Async reset mid-operation: all state returns to reset values immediately; in-flight samples are discarded.

Decomposition:
- Package lockin_pkg: W_IN/W_OUT/G defaults, accumulator width function (W_IN+G+1), settle multiplier constant (8), saturation limits.
- Sub-module lpf_channel (instantiated for I and Q): accumulator update, round/saturate, per-channel ovf flag.
- The top lockin_lpf owns the decimation counter, settle counter, k latch, clear logic, valid pipeline and ovf OR.

Test Plan:
- Pass-through: k=0, dec=1, i_in=0x12345678, q_in=0x12348000, one in_valid -> out_valid 2 cycles later, i_out=0x1234, q_out=0x1235, ovf=0.
- Step response: k=4, dec=1, i_in=0x40000000 held, 16 strobes -> i_out within ±2 of 10550 (0x2936); settled=0 after 127 samples, =1 after 128.
- Decimation: dec_ratio=5, 20 strobes spaced 3 cycles -> exactly 4 out_valid pulses, on samples 5, 10, 15, 20; dec_ratio=0 -> pulse every sample.
- Saturation: k=0, i_in=0x7FFF8000 -> i_out=0x7FFF, ovf=1 and it stays 1; clear -> ovf=0.
- Clear/collision: steady state at 0x4000, assert clear with in_valid -> no out_valid, next sample x=0 gives i_out=0, settled=0; k changed 4->6 mid-run -> settled drops, reasserts after 512 samples.
- Async reset mid-pipeline: drop rst the cycle after an emitting in_valid -> out_valid never asserts, all outputs 0 asynchronously.
